cnn_job_arbiter: RTL and testbench
==================================

Name: cnn_job_arbiter

Overview:
- Round-robin scheduler sharing one CNN inference engine among NUM_REQ image requesters (camera or DMA channels).
- Grants one requester at a time and drives the engine's level start/done handshake.
- Returns a tagged per-job result and cycle latency.
- Sits between requester channels and the CNN engine top; eng_sel steers the external image mux.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- IDX_W, $clog2(NUM_REQ), requester index width
- LAT_W, 24, latency counter width
- TIMEOUT_CYCLES, 200000, watchdog limit in RUN (used only with the watchdog macro)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req  in  NUM_REQ  per-requester level request
- gnt  out  NUM_REQ  one-hot grant, held for the whole job
- eng_sel  out  IDX_W  index of the granted requester, for the image mux
- eng_start  out  1  engine start level
- eng_done  in  1  engine done level
- eng_result  in  1  engine class output (1 diseased, 0 healthy)
- eng_abort  out  1  one-cycle engine reset pulse on timeout
- res_valid  out  1  one-cycle result strobe
- res_id  out  IDX_W  requester owning the result
- res_data  out  1  captured eng_result
- res_err  out  1  job timed out; res_data forced 0
- res_latency  out  LAT_W  cycles spent in RUN, saturating
- busy  out  1  high in every state except IDLE
- job_count  out  16  completed-job counter (including errors), wraps

Behaviour:
- Reset (rst_n low at a clk edge): all outputs 0, state IDLE, rr_ptr 0.
- Reset mid-job: drops eng_start next edge and discards the job; no res_valid.
- States: IDLE, GRANT, RUN, DRAIN.
- IDLE:
  - If req is nonzero, pick the winner: first set bit scanning from rr_ptr upward, mod NUM_REQ.
  - Register eng_sel and gnt (one-hot), go to GRANT.
  - Grant is visible one cycle after req is sampled.
- GRANT (1 cycle):
  - eng_start <= 1, lat_cnt <= 0, go to RUN.
  - The one cycle lets the image mux settle before the engine samples it.
- RUN:
  - eng_start held 1; lat_cnt increments each cycle and saturates at all-ones.
  - On eng_done=1: capture eng_result, eng_start <= 0, go to DRAIN.
- DRAIN:
  - Wait until eng_done=0; the engine returns to its idle state only after start drops.
  - Then, on a single edge:
    - res_valid=1 for one cycle
    - res_id=eng_sel, res_data=captured result, res_err=captured error flag
    - res_latency=lat_cnt
    - gnt <= 0, job_count++, rr_ptr <= eng_sel+1 mod NUM_REQ
    - go to IDLE
  - res_id, res_data, res_err and res_latency hold until the next res_valid.
- Requester rules:
  - Keep req high until res_valid for its id; req is not sampled while busy.
  - A requester deasserting req mid-job does not cancel the job.
  - A re-asserted req is served fairly: rr_ptr has moved past it.
- No new grant in the IDLE cycle that coincides with res_valid. Back-to-back jobs are therefore separated by at least one IDLE cycle.
- Exactly one gnt bit is high whenever busy=1; gnt is all-zero in IDLE.
- eng_done high while in IDLE or GRANT is ignored.

Optional Feature:
- Macro: CNN_ARB_WATCHDOG_EN.
- Defined:
  - In RUN, if lat_cnt reaches TIMEOUT_CYCLES-1 with eng_done still 0:
    - eng_start <= 0
    - eng_abort=1 for exactly one cycle
    - error flag set, captured result forced 0
    - go to DRAIN (normally sees eng_done=0 immediately)
  - The result reports res_err=1, res_data=0.
  - eng_done arriving in the same cycle as the timeout wins: normal completion, no abort.
- Undefined: RUN waits indefinitely; eng_abort and res_err tied 0; TIMEOUT_CYCLES unused.

Test Plan:
- Single job: req=4'b0010; engine model asserts done after 50 cycles of start with result=1 -> gnt=4'b0010 one cycle after req, eng_sel=1, res_valid with res_id=1, res_data=1, res_latency=50, job_count=1.
- Round-robin: req=4'b1111 held, each job 10 cycles -> grant order 0,1,2,3,0; never two gnt bits high; job_count=5.
- Fairness after service: rr_ptr=2, req=4'b0101 -> requester 2 granted first, then 0.
- Drain handshake: engine holds done high 5 cycles after start drops -> res_valid fires only on the edge after done falls; eng_start stays 0 throughout DRAIN.
- Reset mid-RUN: rst_n low for 1 cycle at latency 20 -> all outputs 0 next cycle, no res_valid, job_count unchanged.
- Watchdog (CNN_ARB_WATCHDOG_EN, TIMEOUT_CYCLES=100), engine never finishes -> eng_abort pulses once when lat_cnt=99; res_valid with res_err=1, res_data=0; next requester granted afterwards.

Source files
------------

// File: rtl/cnn_job_arbiter_if.sv
// ============================================================================
// Module   : cnn_job_arbiter_if
// Brief    : Requester, engine and result signals shared by cnn_job_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnn_job_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ),
  parameter int LAT_W   = 24
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   eng_sel;
  logic               eng_start;
  logic               eng_done;
  logic               eng_result;
  logic               eng_abort;
  logic               res_valid;
  logic [IDX_W-1:0]   res_id;
  logic               res_data;
  logic               res_err;
  logic [LAT_W-1:0]   res_latency;
  logic               busy;
  logic [15:0]        job_count;

  modport master (
    input  req, eng_done, eng_result,
    output gnt, eng_sel, eng_start, eng_abort,
    output res_valid, res_id, res_data, res_err, res_latency, busy, job_count
  );

  modport slave (
    output req, eng_done, eng_result,
    input  gnt, eng_sel, eng_start, eng_abort,
    input  res_valid, res_id, res_data, res_err, res_latency, busy, job_count
  );
endinterface

`default_nettype wire

// File: rtl/cnn_job_arbiter.sv
// ============================================================================
// Module   : cnn_job_arbiter
// Brief    : Round-robin scheduler sharing one CNN engine among NUM_REQ
//            requesters; optional RUN watchdog under CNN_ARB_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = $clog2(NUM_REQ),
  parameter int LAT_W          = 24,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic              clk,
  input  logic              rst_n,
  cnn_job_arbiter_if.master bus
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_GRANT = 2'd1;
  localparam logic [1:0] c_ST_RUN   = 2'd2;
  localparam logic [1:0] c_ST_DRAIN = 2'd3;

  localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]     c_NUM_REQ  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] c_GNT_ONE  = NUM_REQ'(1);
  localparam logic [LAT_W-1:0]   c_LAT_MAX  = '1;
  localparam logic [LAT_W-1:0]   c_LAT_ONE  = LAT_W'(1);

  generate
    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("cnn_job_arbiter: parameter out of range");
    end
  endgenerate

  logic [1:0]         r_state;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   r_sel;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_start;
  logic [LAT_W-1:0]   r_lat;
  logic               r_cap_data;
  logic               r_res_valid;
  logic [IDX_W-1:0]   r_res_id;
  logic               r_res_data;
  logic [LAT_W-1:0]   r_res_lat;
  logic [15:0]        r_job_cnt;

  logic               w_pick_found;
  logic [IDX_W-1:0]   w_pick_idx;
  logic [IDX_W:0]     w_cand;

  // Rotating priority: the lowest offset from r_rr_ptr with req set wins.
  always_comb begin
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W + 1)'(i);
      if (w_cand >= c_NUM_REQ) begin
        w_cand = w_cand - c_NUM_REQ;
      end
      if (!w_pick_found && bus.req[w_cand[IDX_W-1:0]]) begin
        w_pick_found = 1'b1;
        w_pick_idx   = w_cand[IDX_W-1:0];
      end
    end
  end

`ifdef CNN_ARB_WATCHDOG_EN
  localparam logic [LAT_W-1:0] c_TIMEOUT_LAST = LAT_W'(TIMEOUT_CYCLES - 1);
  logic r_abort;
  logic r_cap_err;
  logic r_res_err;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_rr_ptr    <= '0;
      r_sel       <= '0;
      r_gnt       <= '0;
      r_start     <= 1'b0;
      r_lat       <= '0;
      r_cap_data  <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= 1'b0;
      r_res_lat   <= '0;
      r_job_cnt   <= '0;
`ifdef CNN_ARB_WATCHDOG_EN
      r_abort     <= 1'b0;
      r_cap_err   <= 1'b0;
      r_res_err   <= 1'b0;
`endif
    end else begin
      r_res_valid <= 1'b0;
`ifdef CNN_ARB_WATCHDOG_EN
      r_abort     <= 1'b0;
`endif
      case (r_state)
        c_ST_IDLE: begin
          // Holding off while res_valid is high guarantees a visible idle gap.
          if (w_pick_found && !r_res_valid) begin
            r_sel   <= w_pick_idx;
            r_gnt   <= c_GNT_ONE << w_pick_idx;
            r_state <= c_ST_GRANT;
          end
        end
        c_ST_GRANT: begin
          r_start    <= 1'b1;
          r_lat      <= '0;
          r_cap_data <= 1'b0;
`ifdef CNN_ARB_WATCHDOG_EN
          r_cap_err  <= 1'b0;
`endif
          r_state    <= c_ST_RUN;
        end
        c_ST_RUN: begin
          if (bus.eng_done) begin
            r_cap_data <= bus.eng_result;
            r_start    <= 1'b0;
            r_state    <= c_ST_DRAIN;
          end
`ifdef CNN_ARB_WATCHDOG_EN
          else if (r_lat == c_TIMEOUT_LAST) begin
            r_start    <= 1'b0;
            r_abort    <= 1'b1;
            r_cap_err  <= 1'b1;
            r_cap_data <= 1'b0;
            r_state    <= c_ST_DRAIN;
          end
`endif
          else if (r_lat != c_LAT_MAX) begin
            r_lat <= r_lat + c_LAT_ONE;
          end
        end
        c_ST_DRAIN: begin
          // The engine only returns to idle once start is low and done falls.
          if (!bus.eng_done) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_sel;
            r_res_data  <= r_cap_data;
            r_res_lat   <= r_lat;
`ifdef CNN_ARB_WATCHDOG_EN
            r_res_err   <= r_cap_err;
`endif
            r_gnt       <= '0;
            r_job_cnt   <= r_job_cnt + 16'd1;
            r_rr_ptr    <= (r_sel == c_LAST_IDX) ? '0 : r_sel + 1'b1;
            r_state     <= c_ST_IDLE;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.eng_sel     = r_sel;
  assign bus.eng_start   = r_start;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_id      = r_res_id;
  assign bus.res_data    = r_res_data;
  assign bus.res_latency = r_res_lat;
  assign bus.busy        = (r_state != c_ST_IDLE);
  assign bus.job_count   = r_job_cnt;
`ifdef CNN_ARB_WATCHDOG_EN
  assign bus.eng_abort   = r_abort;
  assign bus.res_err     = r_res_err;
`else
  assign bus.eng_abort   = 1'b0;
  assign bus.res_err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cnn_job_arbiter.sv
// Directed bench for cnn_job_arbiter with a behavioural CNN engine model.
`timescale 1ns/1ps
`default_nettype none

module tb_cnn_job_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int LAT_W   = 24;
  localparam int TMO     = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnn_job_arbiter_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .LAT_W(LAT_W)) bus ();

  cnn_job_arbiter #(
    .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .LAT_W(LAT_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Engine model: done rises after job_len cycles of start, falls done_hold
  // cycles after start drops.
  int job_len   = 10;
  int done_hold = 0;
  bit eng_res   = 1'b0;
  int eng_cnt   = 0;
  int hold_cnt  = 0;

  assign bus.eng_result = eng_res;

  always @(posedge clk) begin
    if (!rst_n) begin
      eng_cnt      <= 0;
      hold_cnt     <= 0;
      bus.eng_done <= 1'b0;
    end else if (bus.eng_start) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt + 1 >= job_len) bus.eng_done <= 1'b1;
    end else begin
      eng_cnt <= 0;
      if (bus.eng_done) begin
        if (hold_cnt >= done_hold) begin
          bus.eng_done <= 1'b0;
          hold_cnt     <= 0;
        end else begin
          hold_cnt <= hold_cnt + 1;
        end
      end
    end
  end

  int inv_err   = 0;
  int abort_cnt = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.busy ? !$onehot(bus.gnt) : (bus.gnt != '0)) inv_err <= inv_err + 1;
      if (bus.eng_abort) abort_cnt <= abort_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_res(input int budget, output bit ok, output int drain_cyc,
                          output bit start_in_drain);
    bit prev_start;
    bit dropped;
    ok = 1'b0; drain_cyc = 0; start_in_drain = 1'b0; dropped = 1'b0;
    prev_start = bus.eng_start;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dropped) begin
        drain_cyc++;
        if (bus.eng_start) start_in_drain = 1'b1;
      end else if (prev_start && !bus.eng_start) begin
        dropped = 1'b1;
      end
      prev_start = bus.eng_start;
      if (bus.res_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] req;
    int         len;
    bit         result;
    int         hold;
    int         exp_id;
    int         exp_lat;
    int         exp_jobs;
  } vec_t;

  vec_t tbl [5];
  int   rr_exp [5];

  initial begin : watchdog_timer
    #500_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit sid;
    int dc;
    int nres;
    int cyc;
    int ab0;

    tbl[0] = '{req: 4'b0010, len: 50, result: 1'b1, hold: 0, exp_id: 1, exp_lat: 50, exp_jobs: 1};
    tbl[1] = '{req: 4'b0101, len: 7,  result: 1'b0, hold: 0, exp_id: 2, exp_lat: 7,  exp_jobs: 2};
    tbl[2] = '{req: 4'b0101, len: 3,  result: 1'b1, hold: 5, exp_id: 0, exp_lat: 3,  exp_jobs: 3};
    tbl[3] = '{req: 4'b1000, len: 1,  result: 1'b0, hold: 0, exp_id: 3, exp_lat: 1,  exp_jobs: 4};
    tbl[4] = '{req: 4'b1001, len: 12, result: 1'b1, hold: 2, exp_id: 0, exp_lat: 12, exp_jobs: 5};
    rr_exp = '{0, 1, 2, 3, 0};

    // Reset state
    bus.req = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", bus.gnt, 0);
    check("rst_eng_sel", bus.eng_sel, 0);
    check("rst_eng_start", bus.eng_start, 0);
    check("rst_eng_abort", bus.eng_abort, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_err", bus.res_err, 0);
    check("rst_res_latency", bus.res_latency, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_job_count", bus.job_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of RUN discards the job
    job_len = 100000; bus.req = 4'b0100;
    @(negedge clk);
    check("mr_gnt", bus.gnt, 4'b0100);
    @(negedge clk);
    check("mr_start", bus.eng_start, 1);
    repeat (20) @(negedge clk);
    rst_n = 1'b0; bus.req = '0;
    @(negedge clk);
    check("mr_gnt_after", bus.gnt, 0);
    check("mr_start_after", bus.eng_start, 0);
    check("mr_busy_after", bus.busy, 0);
    check("mr_jobs_after", bus.job_count, 0);
    rst_n = 1'b1;
    nres = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.res_valid) nres++;
    end
    check("mr_no_res_valid", nres, 0);

    // Table-driven single jobs
    for (int v = 0; v < 5; v++) begin
      job_len = tbl[v].len; eng_res = tbl[v].result; done_hold = tbl[v].hold;
      bus.req = tbl[v].req;
      @(negedge clk);
      check($sformatf("v%0d_gnt", v), bus.gnt, 4'b0001 << tbl[v].exp_id);
      check($sformatf("v%0d_eng_sel", v), bus.eng_sel, tbl[v].exp_id);
      check($sformatf("v%0d_busy", v), bus.busy, 1);
      check($sformatf("v%0d_start_in_grant", v), bus.eng_start, 0);
      @(negedge clk);
      check($sformatf("v%0d_start_in_run", v), bus.eng_start, 1);
      wait_res(2000, ok, dc, sid);
      check($sformatf("v%0d_res_seen", v), ok, 1);
      check($sformatf("v%0d_res_id", v), bus.res_id, tbl[v].exp_id);
      check($sformatf("v%0d_res_data", v), bus.res_data, tbl[v].result);
      check($sformatf("v%0d_res_err", v), bus.res_err, 0);
      check($sformatf("v%0d_res_latency", v), bus.res_latency, tbl[v].exp_lat);
      check($sformatf("v%0d_job_count", v), bus.job_count, tbl[v].exp_jobs);
      check($sformatf("v%0d_drain_cycles", v), dc, 2 + tbl[v].hold);
      check($sformatf("v%0d_start_in_drain", v), sid, 0);
      check($sformatf("v%0d_done_low_at_res", v), bus.eng_done, 0);
      bus.req = '0;
      @(negedge clk);
      check($sformatf("v%0d_res_pulse", v), bus.res_valid, 0);
      check($sformatf("v%0d_idle", v), bus.busy, 0);
      check($sformatf("v%0d_res_id_hold", v), bus.res_id, tbl[v].exp_id);
    end

    // Round robin with all requesters held high
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    job_len = 10; done_hold = 0; eng_res = 1'b0;
    bus.req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_res(500, ok, dc, sid);
      check($sformatf("rr%0d_res_seen", j), ok, 1);
      check($sformatf("rr%0d_res_id", j), bus.res_id, rr_exp[j]);
      @(negedge clk);
      check($sformatf("rr%0d_idle_gap", j), bus.busy, 0);
      if (j == 4) bus.req = '0;
    end
    check("rr_job_count", bus.job_count, 5);
    repeat (3) @(negedge clk);
    check("rr_stays_idle", bus.busy, 0);

`ifdef CNN_ARB_WATCHDOG_EN
    // Engine never finishes: watchdog aborts, next requester served
    ab0 = abort_cnt;
    job_len = 1000000; eng_res = 1'b1; bus.req = 4'b0110;
    @(negedge clk);
    check("wd_gnt", bus.gnt, 4'b0010);
    @(negedge clk);
    ok = 1'b0; cyc = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      cyc++;
      if (bus.eng_abort) begin
        ok = 1'b1;
        break;
      end
    end
    check("wd_abort_seen", ok, 1);
    check("wd_abort_delay", cyc, TMO);
    check("wd_start_low_at_abort", bus.eng_start, 0);
    wait_res(10, ok, dc, sid);
    check("wd_res_seen", ok, 1);
    check("wd_abort_single_cycle", bus.eng_abort, 0);
    check("wd_res_id", bus.res_id, 1);
    check("wd_res_err", bus.res_err, 1);
    check("wd_res_data", bus.res_data, 0);
    check("wd_res_latency", bus.res_latency, TMO - 1);
    bus.req = 4'b0100; job_len = 5;
    @(negedge clk);
    @(negedge clk);
    check("wd_next_gnt", bus.gnt, 4'b0100);
    @(negedge clk);
    wait_res(100, ok, dc, sid);
    check("wd_next_res_seen", ok, 1);
    check("wd_next_res_err", bus.res_err, 0);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("wd_abort_count", abort_cnt - ab0, 1);
`else
    ab0 = abort_cnt;
    cyc = 0;
    check("no_abort_without_watchdog", ab0 + cyc, 0);
`endif

    check("gnt_invariants", inv_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
